// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared FSM encoding, arbitration mode codes and packed-bus helpers
// for the DDR burst arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // LSB position of channel idx inside a packed per-channel bus of the given field width
  function automatic int unsigned ch_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  // Channel following idx in round-robin order, wrapping to 0 after the last channel
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_ch);
    int unsigned nxt;
    if (idx + 32'd1 >= num_ch) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ddr_arb_picker.sv
// ddr_arb_picker: combinational winner select. Round-robin scans upward from the
// pointer with wrap; fixed priority scans upward from channel 0.
module ddr_arb_picker
  import ddr_arb_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  localparam int CH_ID_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  req_i,
  input  logic [CH_ID_W-1:0] ptr_i,
  input  logic               fixed_i,
  output logic [NUM_CH-1:0]  grant_o,
  output logic [CH_ID_W-1:0] idx_o,
  output logic               any_o
);

  // Channel index examined at each scan position
  logic [CH_ID_W-1:0] cand_s [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cand
    assign cand_s[k] = fixed_i ? CH_ID_W'(k)
                               : CH_ID_W'((int'(ptr_i) + k) % NUM_CH);
  end

  // First requesting candidate in scan order wins
  always_comb begin
    grant_o = {NUM_CH{1'b0}};
    idx_o   = {CH_ID_W{1'b0}};
    any_o   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any_o && req_i[cand_s[k]]) begin
        grant_o[cand_s[k]] = 1'b1;
        idx_o              = cand_s[k];
        any_o              = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: N-channel arbiter in front of the single DDR burst port.
// Latches the winner's request at grant, steers beats to/from the owner and
// checks each burst with a stall watchdog and a beat-count comparison.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int DDR_ADDR_WIDTH = 28,
  parameter  int DDR_DATA_WIDTH = 128,
  parameter  int LEN_WIDTH      = 10,
  parameter  int PRIO_MODE      = 0,
  parameter  int TIMEOUT_CYC    = 4096,
  localparam int CH_ID_W        = $clog2(NUM_CH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init_calib_complete,
  input  logic [NUM_CH-1:0]                  ch_req,
  input  logic [NUM_CH-1:0]                  ch_wr,
  input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_len,
  input  logic [NUM_CH*DDR_DATA_WIDTH-1:0]   ch_wr_data,
  output logic [NUM_CH-1:0]                  ch_grant,
  output logic [NUM_CH-1:0]                  ch_done,
  output logic [NUM_CH-1:0]                  ch_err,
  output logic [NUM_CH-1:0]                  ch_wr_data_req,
  output logic [NUM_CH-1:0]                  ch_rd_valid,
  output logic [DDR_DATA_WIDTH-1:0]          ch_rd_data,
  output logic                               busy,
  output logic [CH_ID_W-1:0]                 active_ch,
  output logic                               rd_burst_req,
  output logic                               wr_burst_req,
  output logic [LEN_WIDTH-1:0]               rd_burst_len,
  output logic [LEN_WIDTH-1:0]               wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
  output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data,
  input  logic                               wr_burst_data_req,
  input  logic                               rd_burst_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
  input  logic                               rd_burst_finish,
  input  logic                               wr_burst_finish
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LEN_WIDTH:0] CNT_MAX = {(LEN_WIDTH+1){1'b1}};
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_e                state_q, state_d;
  logic [CH_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CH_ID_W-1:0]        active_q, active_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [NUM_CH-1:0]         grant_q, grant_d;
  logic [NUM_CH-1:0]         done_q, done_d;
  logic [NUM_CH-1:0]         err_q, err_d;
  logic                      rd_req_q, rd_req_d;
  logic                      wr_req_q, wr_req_d;
  logic                      busy_q, busy_d;
  logic [LEN_WIDTH:0]        beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]           idle_cnt_q, idle_cnt_d;

  // Per-channel views of the packed request buses
  logic [DDR_ADDR_WIDTH-1:0] addr_arr_s  [NUM_CH];
  logic [LEN_WIDTH-1:0]      len_arr_s   [NUM_CH];
  logic [DDR_DATA_WIDTH-1:0] wdata_arr_s [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr_s[i]  = ch_addr[ch_lsb(i, DDR_ADDR_WIDTH) +: DDR_ADDR_WIDTH];
    assign len_arr_s[i]   = ch_len[ch_lsb(i, LEN_WIDTH) +: LEN_WIDTH];
    assign wdata_arr_s[i] = ch_wr_data[ch_lsb(i, DDR_DATA_WIDTH) +: DDR_DATA_WIDTH];
  end

  logic [NUM_CH-1:0]  pick_grant_s;
  logic [CH_ID_W-1:0] pick_idx_s;
  logic               pick_any_s;
  logic [LEN_WIDTH-1:0] pick_len_s;

  ddr_arb_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i   (ch_req),
    .ptr_i   (rr_ptr_q),
    .fixed_i (PRIO_MODE == PRIO_FIXED),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  logic               in_burst_s;
  logic               beat_s;
  logic               finish_s;
  logic               timeout_s;
  logic               start_s;
  logic               len_ok_s;
  logic [LEN_WIDTH:0] beat_total_s;

  assign pick_len_s   = len_arr_s[pick_idx_s];
  assign in_burst_s   = (state_q == RD) || (state_q == WR);
  assign beat_s       = ((state_q == RD) && rd_burst_data_valid) ||
                        ((state_q == WR) && wr_burst_data_req);
  assign finish_s     = ((state_q == RD) && rd_burst_finish) ||
                        ((state_q == WR) && wr_burst_finish);
  // Watchdog fires only on a cycle with neither a beat nor a finish
  assign timeout_s    = in_burst_s && !beat_s && !finish_s && (idle_cnt_q == TO_LAST);
  assign start_s      = (state_q == IDLE) && init_calib_complete && pick_any_s;
  // A beat arriving together with the finish is counted before the length check
  assign beat_total_s = (beat_s && (beat_cnt_q != CNT_MAX)) ? beat_cnt_q + 1'b1 : beat_cnt_q;
  assign len_ok_s     = (beat_total_s == {1'b0, len_q});

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!start_s) begin
          state_d = IDLE;
        end else if (pick_len_s == {LEN_WIDTH{1'b0}}) begin
          state_d = DONE;
        end else if (ch_wr[pick_idx_s]) begin
          state_d = WR;
        end else begin
          state_d = RD;
        end
      end
      RD, WR: begin
        if (finish_s || timeout_s) begin
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output and datapath next values
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    active_d   = active_q;
    addr_d     = addr_q;
    len_d      = len_q;
    grant_d    = grant_q;
    done_d     = {NUM_CH{1'b0}};
    err_d      = {NUM_CH{1'b0}};
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start_s) begin
          active_d   = pick_idx_s;
          addr_d     = addr_arr_s[pick_idx_s];
          len_d      = pick_len_s;
          beat_cnt_d = {(LEN_WIDTH+1){1'b0}};
          idle_cnt_d = {TO_W{1'b0}};
          if (state_d == DONE) begin
            // Zero-length request: no DDR traffic, report completion directly
            done_d = pick_grant_s;
          end else begin
            grant_d  = pick_grant_s;
            rd_req_d = (state_d == RD);
            wr_req_d = (state_d == WR);
          end
        end else begin
          grant_d = {NUM_CH{1'b0}};
        end
      end
      RD, WR: begin
        beat_cnt_d = beat_total_s;
        idle_cnt_d = beat_s ? {TO_W{1'b0}} : idle_cnt_q + 1'b1;
        if (finish_s || timeout_s) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          grant_d  = {NUM_CH{1'b0}};
          if (finish_s && len_ok_s) begin
            done_d = grant_q;
          end else begin
            err_d = grant_q;
          end
        end else begin
          grant_d = grant_q;
        end
      end
      DONE: begin
        grant_d  = {NUM_CH{1'b0}};
        rr_ptr_d = CH_ID_W'(rr_next(32'(active_q), NUM_CH));
      end
      default: begin
        grant_d  = {NUM_CH{1'b0}};
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered output state
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= {CH_ID_W{1'b0}};
      active_q   <= {CH_ID_W{1'b0}};
      addr_q     <= {DDR_ADDR_WIDTH{1'b0}};
      len_q      <= {LEN_WIDTH{1'b0}};
      grant_q    <= {NUM_CH{1'b0}};
      done_q     <= {NUM_CH{1'b0}};
      err_q      <= {NUM_CH{1'b0}};
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      beat_cnt_q <= {(LEN_WIDTH+1){1'b0}};
      idle_cnt_q <= {TO_W{1'b0}};
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      active_q   <= active_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign ch_grant      = grant_q;
  assign ch_done       = done_q;
  assign ch_err        = err_q;
  assign busy          = busy_q;
  assign active_ch     = active_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_len  = len_q;
  assign wr_burst_len  = len_q;
  assign rd_burst_addr = addr_q;
  assign wr_burst_addr = addr_q;

  // Beat strobes reach only the owner and only while its burst is live
  assign ch_rd_valid    = ((state_q == RD) && rd_burst_data_valid) ? grant_q : {NUM_CH{1'b0}};
  assign ch_wr_data_req = ((state_q == WR) && wr_burst_data_req)   ? grant_q : {NUM_CH{1'b0}};
  assign wr_burst_data  = (state_q == WR) ? wdata_arr_s[active_q] : {DDR_DATA_WIDTH{1'b0}};
  assign ch_rd_data     = rd_burst_data;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: directed vectors for the DDR burst arbiter. A second
// instance in fixed-priority mode is served by a one-beat auto-responder.
module tb_ddr_burst_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int LW = 10;
  localparam int TO = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic            init_calib_complete;
  logic [N-1:0]    ch_req, ch_wr;
  logic [N*AW-1:0] ch_addr;
  logic [N*LW-1:0] ch_len;
  logic [N*DW-1:0] ch_wr_data;
  logic [N-1:0]    ch_grant, ch_done, ch_err, ch_wr_data_req, ch_rd_valid;
  logic [DW-1:0]   ch_rd_data;
  logic            busy;
  logic [1:0]      active_ch;
  logic            rd_burst_req, wr_burst_req;
  logic [LW-1:0]   rd_burst_len, wr_burst_len;
  logic [AW-1:0]   rd_burst_addr, wr_burst_addr;
  logic [DW-1:0]   wr_burst_data;
  logic            wr_burst_data_req, rd_burst_data_valid;
  logic [DW-1:0]   rd_burst_data;
  logic            rd_burst_finish, wr_burst_finish;

  logic [N-1:0]    fx_grant, fx_done, fx_err, fx_wdreq_o, fx_rvalid_o;
  logic [DW-1:0]   fx_rdata_o, fx_wdata;
  logic            fx_busy, fx_rd_req, fx_wr_req;
  logic [1:0]      fx_active;
  logic [LW-1:0]   fx_rlen, fx_wlen;
  logic [AW-1:0]   fx_raddr, fx_waddr;
  logic            fx_rvalid, fx_wdreq;
  logic [DW-1:0]   fx_rdata = '0;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  ddr_burst_arbiter #(.NUM_CH(N), .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW),
                      .LEN_WIDTH(LW), .PRIO_MODE(0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wr_data(ch_wr_data), .ch_grant(ch_grant), .ch_done(ch_done), .ch_err(ch_err),
    .ch_wr_data_req(ch_wr_data_req), .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data),
    .busy(busy), .active_ch(active_ch), .rd_burst_req(rd_burst_req),
    .wr_burst_req(wr_burst_req), .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish));

  ddr_burst_arbiter #(.NUM_CH(N), .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW),
                      .LEN_WIDTH(LW), .PRIO_MODE(1), .TIMEOUT_CYC(TO)) dut_fx (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wr_data(ch_wr_data), .ch_grant(fx_grant), .ch_done(fx_done), .ch_err(fx_err),
    .ch_wr_data_req(fx_wdreq_o), .ch_rd_valid(fx_rvalid_o), .ch_rd_data(fx_rdata_o),
    .busy(fx_busy), .active_ch(fx_active), .rd_burst_req(fx_rd_req),
    .wr_burst_req(fx_wr_req), .rd_burst_len(fx_rlen), .wr_burst_len(fx_wlen),
    .rd_burst_addr(fx_raddr), .wr_burst_addr(fx_waddr),
    .wr_burst_data(fx_wdata), .wr_burst_data_req(fx_wdreq),
    .rd_burst_data_valid(fx_rvalid), .rd_burst_data(fx_rdata),
    .rd_burst_finish(fx_rvalid), .wr_burst_finish(fx_wdreq));

  // One-beat responder for the fixed-priority instance: beat and finish together
  always @(posedge clk) begin
    if (!rst) begin
      fx_rvalid <= 1'b0;
      fx_wdreq  <= 1'b0;
    end else begin
      fx_rvalid <= fx_rd_req && !fx_rvalid;
      fx_wdreq  <= fx_wr_req && !fx_wdreq;
    end
  end

  task automatic check_vec(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobes_off();
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data       = '0;
  endtask

  task automatic do_reset();
    ch_req = '0;
    strobes_off();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int wait_n;
    rst = 1'b0;
    init_calib_complete = 1'b0;
    ch_req = '0; ch_wr = '0; ch_addr = '0; ch_len = '0; ch_wr_data = '0;
    strobes_off();

    // Reset, then calibration gating
    repeat (3) @(negedge clk);
    check_vec("reset_ctl", {ch_grant, ch_done, ch_err, ch_wr_data_req, ch_rd_valid,
                            busy, active_ch, rd_burst_req, wr_burst_req}, '0);
    check_vec("reset_lenaddr", {rd_burst_len, wr_burst_len, rd_burst_addr, wr_burst_addr}, '0);
    rst = 1'b1;
    ch_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_vec("calib_idle", {busy, ch_grant, rd_burst_req, wr_burst_req}, '0);
    end

    // Single read on channel 2
    do_reset();
    init_calib_complete = 1'b1;
    ch_addr[2*AW +: AW] = 28'h100;
    ch_len[2*LW +: LW]  = 10'd4;
    ch_req = 4'b0100;
    @(negedge clk);
    check_vec("rd_grant", ch_grant, 4'b0100);
    check_vec("rd_addr", rd_burst_addr, 28'h100);
    check_vec("rd_len", rd_burst_len, 10'd4);
    check_vec("rd_reqs", {rd_burst_req, wr_burst_req, active_ch, busy}, 5'b10_10_1);
    ch_req = '0;
    for (int k = 0; k < 4; k++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = 128'hC0DE_0000 + 128'(k);
      rd_burst_finish     = (k == 3);
      #1;
      check_vec("rd_valid", ch_rd_valid, 4'b0100);
      check_vec("rd_data", ch_rd_data, 128'hC0DE_0000 + 128'(k));
      @(negedge clk);
    end
    strobes_off();
    check_vec("rd_done", {ch_done, ch_err, ch_grant, rd_burst_req}, {4'b0100, 4'b0, 4'b0, 1'b0});
    @(negedge clk);
    check_vec("rd_done_once", {ch_done, ch_err, busy}, '0);

    // Round-robin fairness, all channels requesting single-beat reads
    do_reset();
    ch_wr = '0;
    for (int i = 0; i < N; i++) ch_len[i*LW +: LW] = 10'd1;
    ch_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_n = 0;
      while (ch_grant == '0 && wait_n < 8) begin
        @(negedge clk);
        wait_n++;
      end
      check_vec("rr_order", ch_grant, 4'b0001 << rr_exp[n]);
      rd_burst_data_valid = 1'b1;
      rd_burst_finish     = 1'b1;
      @(negedge clk);
      strobes_off();
      check_vec("rr_done", ch_done, 4'b0001 << rr_exp[n]);
    end

    // Fixed priority: channel 0 wins every time
    do_reset();
    ch_req = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      wait_n = 0;
      while (fx_grant == '0 && wait_n < 12) begin
        @(negedge clk);
        wait_n++;
      end
      check_vec("fx_order", fx_grant, 4'b0001);
      wait_n = 0;
      while (fx_grant != '0 && wait_n < 12) begin
        @(negedge clk);
        wait_n++;
      end
    end

    // Write steering on channel 1 with a decoy on channel 3
    do_reset();
    ch_wr_data[1*DW +: DW] = {16{8'hA5}};
    ch_wr_data[3*DW +: DW] = {16{8'h5A}};
    ch_wr  = 4'b0010;
    ch_addr[1*AW +: AW] = 28'h0ABCDE0;
    ch_len[1*LW +: LW]  = 10'd2;
    ch_req = 4'b0010;
    @(negedge clk);
    check_vec("wr_grant", {ch_grant, rd_burst_req, wr_burst_req}, {4'b0010, 2'b01});
    check_vec("wr_addrlen", {wr_burst_addr, wr_burst_len}, {28'h0ABCDE0, 10'd2});
    ch_req = '0;
    for (int k = 0; k < 2; k++) begin
      wr_burst_data_req = 1'b1;
      wr_burst_finish   = (k == 1);
      #1;
      check_vec("wr_data", wr_burst_data, {16{8'hA5}});
      check_vec("wr_dreq", ch_wr_data_req, 4'b0010);
      @(negedge clk);
    end
    strobes_off();
    check_vec("wr_done", {ch_done, ch_err}, {4'b0010, 4'b0000});

    // Short read: 5 beats of 8, then finish
    do_reset();
    ch_wr = '0;
    ch_len[0 +: LW] = 10'd8;
    ch_req = 4'b0001;
    @(negedge clk);
    check_vec("short_grant", ch_grant, 4'b0001);
    ch_req = '0;
    for (int k = 0; k < 5; k++) begin
      rd_burst_data_valid = 1'b1;
      @(negedge clk);
    end
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b1;
    @(negedge clk);
    strobes_off();
    check_vec("short_err", {ch_err, ch_done}, {4'b0001, 4'b0000});

    // Stall watchdog with a late finish
    do_reset();
    ch_len[0 +: LW] = 10'd4;
    ch_req = 4'b0001;
    @(negedge clk);
    check_vec("wd_start", rd_burst_req, 1'b1);
    ch_req = '0;
    repeat (TO - 1) @(negedge clk);
    check_vec("wd_hold", {rd_burst_req, ch_err}, {1'b1, 4'b0000});
    @(negedge clk);
    check_vec("wd_abort", {rd_burst_req, ch_err, ch_done}, {1'b0, 4'b0001, 4'b0000});
    rd_burst_finish     = 1'b1;
    rd_burst_data_valid = 1'b1;
    #1;
    check_vec("wd_late_valid", ch_rd_valid, 4'b0000);
    @(negedge clk);
    check_vec("wd_late_fin", {ch_done, ch_err, busy, ch_rd_valid}, '0);
    strobes_off();

    // Zero-length request completes without DDR traffic
    do_reset();
    ch_len[3*LW +: LW] = 10'd0;
    ch_req = 4'b1000;
    @(negedge clk);
    check_vec("len0_done", {ch_done, ch_grant, rd_burst_req, wr_burst_req}, {4'b1000, 4'b0, 2'b00});
    ch_req = '0;
    @(negedge clk);
    check_vec("len0_after", {ch_done, busy}, '0);

    // Reset in the middle of a write burst
    do_reset();
    ch_wr = 4'b0010;
    ch_len[1*LW +: LW] = 10'd4;
    ch_req = 4'b0010;
    @(negedge clk);
    check_vec("mid_wr_start", {wr_burst_req, active_ch}, {1'b1, 2'd1});
    ch_req = '0;
    wr_burst_data_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_vec("mid_rst_ctl", {ch_grant, ch_done, ch_err, ch_wr_data_req, busy, active_ch,
                              rd_burst_req, wr_burst_req}, '0);
    check_vec("mid_rst_data", {wr_burst_len, wr_burst_addr, wr_burst_data}, '0);
    rst = 1'b1;
    strobes_off();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
